// File: rtl/imem_fetch.sv
// Instruction fetch front end: drives the synchronous-read imem port and hands
// {pc, inst} to decode over valid/ready, covering the one-cycle read latency.
module imem_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addrb,
  input  logic [31:0]        imem_doutb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_inst,
  output logic               misaligned,
  output logic [31:0]        fetch_count
);

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic [IMEM_AW-1:0] word_index(input logic [31:0] pc);
    return pc[IMEM_AW+1:2];
  endfunction

  logic        req_vld;
  logic [31:0] req_pc;
  logic [31:0] nxt_pc;

  logic        stall;
  logic        fire;
  logic [31:0] target_pc;
  logic [31:0] seq_pc;
  logic [31:0] issue_pc;

  // Issue stage: choose the address presented to imem this cycle
  always_comb begin
    target_pc = pc_align(redirect_pc);
    seq_pc    = req_vld ? pc_inc(req_pc) : nxt_pc;
    stall     = req_vld & ~out_ready;
    if (redirect_valid)
      issue_pc = target_pc;
    else if (stall)
      issue_pc = req_pc;
    else
      issue_pc = seq_pc;
  end

  // The memory data register is not reset, so point it at the reset vector
  // while reset is held.
  assign imem_addrb = rst_n ? word_index(issue_pc) : word_index(RESET_PC);

  // Response stage: imem_doutb holds data for req_pc
  assign out_valid = req_vld & ~redirect_valid;
  assign out_pc    = req_pc;
  assign out_inst  = imem_doutb;
  assign fire      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld     <= 1'b0;
      req_pc      <= RESET_PC;
      nxt_pc      <= RESET_PC;
      misaligned  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      fetch_count <= fetch_count + {31'd0, fire};
      if (redirect_valid) begin
        req_vld    <= fetch_en;
        req_pc     <= target_pc;
        nxt_pc     <= target_pc;
        misaligned <= |redirect_pc[1:0];
      end else begin
        misaligned <= 1'b0;
        if (stall) begin
          req_vld <= req_vld;
        end else if (!fetch_en) begin
          req_vld <= 1'b0;
          nxt_pc  <= issue_pc;
        end else begin
          req_vld <= 1'b1;
          req_pc  <= issue_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: cycle vector table plus hand-written redirect, wrap
// and mid-stream reset sequences, with a scoreboard of accepted instructions.
module tb_imem_fetch;
  localparam int          AW = 14;
  localparam logic [31:0] B  = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fetch_en = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic [AW-1:0] imem_addrb;
  logic [31:0]   imem_doutb;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          misaligned;
  logic [31:0]   fetch_count;

  always #5 clk = ~clk;

  imem_fetch #(.RESET_PC(B), .IMEM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addrb(imem_addrb), .imem_doutb(imem_doutb),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .misaligned(misaligned), .fetch_count(fetch_count)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i * 3);
  always @(posedge clk) imem_doutb <= mem[imem_addrb];

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {18'd0, pc[AW+1:2]} * 32'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, settle, then score any accept.
  task automatic step(input logic fe, input logic rv, input logic [31:0] rp, input logic rdy);
    logic [31:0] e;
    @(negedge clk);
    fetch_en = fe; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: accepted pc %h with nothing expected", out_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_inst", out_inst, inst_of(e));
      end
    end
  endtask

  typedef struct {
    logic          fe, rv;
    logic [31:0]   rp;
    logic          rdy;
    logic          v;
    logic [31:0]   pc;
    logic [AW-1:0] ab;
    logic          mis;
  } vec_t;

  function automatic vec_t mk(input logic fe, input logic rv, input logic [31:0] rp,
                              input logic rdy, input logic v, input logic [31:0] pc,
                              input int ab, input logic mis);
    vec_t r;
    r.fe = fe; r.rv = rv; r.rp = rp; r.rdy = rdy;
    r.v = v; r.pc = pc; r.ab = AW'(ab); r.mis = mis;
    return r;
  endfunction

  vec_t vec [20];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0]  = mk(1, 0, 0,        1, 1, B,         1,  0);
    vec[1]  = mk(1, 0, 0,        1, 1, B + 4,     2,  0);
    for (int i = 2; i <= 6; i++)
      vec[i] = mk(1, 0, 0,       0, 1, B + 8,     2,  0);
    vec[7]  = mk(1, 0, 0,        1, 1, B + 8,     3,  0);
    vec[8]  = mk(1, 0, 0,        1, 1, B + 12,    4,  0);
    vec[9]  = mk(0, 0, 0,        1, 1, B + 16,    5,  0);
    vec[10] = mk(0, 0, 0,        1, 0, 0,         5,  0);
    vec[11] = mk(0, 0, 0,        1, 0, 0,         5,  0);
    vec[12] = mk(1, 0, 0,        1, 0, 0,         5,  0);
    vec[13] = mk(1, 0, 0,        1, 1, B + 20,    6,  0);
    vec[14] = mk(1, 0, 0,        0, 1, B + 24,    6,  0);
    vec[15] = mk(1, 1, B + 'h100, 0, 0, 0,        64, 0);
    vec[16] = mk(1, 0, 0,        1, 1, B + 'h100, 65, 0);
    vec[17] = mk(1, 1, B + 'h42, 1, 0, 0,         16, 0);
    vec[18] = mk(1, 0, 0,        1, 1, B + 'h40,  17, 1);
    vec[19] = mk(1, 0, 0,        1, 1, B + 'h44,  18, 0);

    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addrb", {18'd0, imem_addrb}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 20; r++) begin
      if (vec[r].v && vec[r].rdy) sb.push_back(vec[r].pc);
      step(vec[r].fe, vec[r].rv, vec[r].rp, vec[r].rdy);
      chk($sformatf("v%0d_valid", r), {31'd0, out_valid}, {31'd0, vec[r].v});
      chk($sformatf("v%0d_addrb", r), {18'd0, imem_addrb}, {18'd0, vec[r].ab});
      chk($sformatf("v%0d_mis", r), {31'd0, misaligned}, {31'd0, vec[r].mis});
      if (vec[r].v) begin
        chk($sformatf("v%0d_pc", r), out_pc, vec[r].pc);
        chk($sformatf("v%0d_inst", r), out_inst, inst_of(vec[r].pc));
      end
    end

    // Redirect to the last word of the index space, then wrap to index 0.
    step(1, 1, B + 'hFFFC, 1);
    chk("wrap_redir_valid", {31'd0, out_valid}, 32'd0);
    chk("wrap_redir_addrb", {18'd0, imem_addrb}, 32'h3FFF);
    chk("count_after_table", fetch_count, 32'd9);
    sb.push_back(B + 'hFFFC);
    step(1, 0, 0, 1);
    chk("wrap_pc", out_pc, B + 'hFFFC);
    chk("wrap_inst", out_inst, 32'h3FFF * 3);
    chk("wrap_mis", {31'd0, misaligned}, 32'd0);
    chk("wrap_addrb", {18'd0, imem_addrb}, 32'd0);
    sb.push_back(32'h1001_0000);
    step(1, 0, 0, 1);
    chk("wrap_next_pc", out_pc, 32'h1001_0000);
    chk("wrap_next_inst", out_inst, 32'd0);
    chk("wrap_next_addrb", {18'd0, imem_addrb}, 32'd1);

    // Asynchronous reset while an instruction is being presented.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    chk("mid_rst_addrb", {18'd0, imem_addrb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(B);
    step(1, 0, 0, 1);
    chk("restart_valid", {31'd0, out_valid}, 32'd1);
    chk("restart_pc", out_pc, B);
    sb.push_back(B + 4);
    step(1, 0, 0, 1);
    chk("restart_count", fetch_count, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
